// File: rtl/cpu_pkg.sv
// Shared CPU definitions: fetch FSM states, reset/NOP constants and control-unit op types.
package cpu_pkg;

   typedef enum logic [1:0] {
      FETCH = 2'd0,
      VALID = 2'd1,
      DRAIN = 2'd2
   } fetch_state_t;

   localparam logic [31:0] NOP_INSTR        = 32'h0000_0013;
   localparam logic [31:0] RESET_PC_DEFAULT = 32'h0000_0000;

   typedef enum logic [3:0] {
      CU_ALU     = 4'd0,
      CU_ALUI    = 4'd1,
      CU_LOAD    = 4'd2,
      CU_STORE   = 4'd3,
      CU_BRANCH  = 4'd4,
      CU_JAL     = 4'd5,
      CU_JALR    = 4'd6,
      CU_LUI     = 4'd7,
      CU_AUIPC   = 4'd8,
      CU_SYSTEM  = 4'd9,
      CU_ILLEGAL = 4'd10
   } cuOPType;

   function automatic logic [31:0] word_align(input logic [31:0] addr);
      return addr & 32'hFFFF_FFFC;
   endfunction

endpackage

// File: rtl/pc_reg.sv
// Program counter and pending request address, with sequential increment and redirect load.
module pc_reg
   import cpu_pkg::*;
#(
   parameter logic [31:0] RESET_PC = RESET_PC_DEFAULT
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        redirect,
   input  logic [31:0] redirect_pc,
   input  logic        advance,
   output logic [31:0] pc,
   output logic [31:0] req_addr,
   output logic [31:0] pc_plus4
);

   assign pc_plus4 = pc + 32'd4;

   // Redirect has priority over the sequential step.
   always_ff @(posedge clk) begin
      if (rst) begin
         pc       <= RESET_PC;
         req_addr <= RESET_PC;
      end else if (redirect) begin
         pc       <= word_align(redirect_pc);
         req_addr <= word_align(redirect_pc);
      end else if (advance) begin
         pc       <= pc_plus4;
         req_addr <= pc_plus4;
      end
   end

endmodule

// File: rtl/instr_fetch.sv
// Instruction fetch unit: one outstanding imem request, single-entry output buffer,
// redirect flush with drain of an in-flight response.
//
// state | meaning
// FETCH | request outstanding at imem_addr, waiting for imem_ready
// VALID | fetched word presented to decode, no request outstanding
// DRAIN | stale request in flight after redirect; response is dropped
module instr_fetch
   import cpu_pkg::*;
#(
   parameter logic [31:0] RESET_PC = RESET_PC_DEFAULT
) (
   input  logic        clk,
   input  logic        rst,
   output logic        imem_ren,
   output logic [31:0] imem_addr,
   input  logic        imem_ready,
   input  logic [31:0] imem_data,
   input  logic        redirect,
   input  logic [31:0] redirect_pc,
   input  logic        instr_ready,
   output logic        instr_valid,
   output logic [31:0] instruction,
   output logic [31:0] pc,
   output logic [31:0] pc_plus4
);

   fetch_state_t state;
   logic [31:0]  req_addr;
   logic [31:0]  target;
   logic         advance;

   assign target  = word_align(redirect_pc);
   assign advance = (state == VALID) && instr_ready && !redirect;

   pc_reg #(
      .RESET_PC (RESET_PC)
   ) u_pc_reg (
      .clk         (clk),
      .rst         (rst),
      .redirect    (redirect),
      .redirect_pc (redirect_pc),
      .advance     (advance),
      .pc          (pc),
      .req_addr    (req_addr),
      .pc_plus4    (pc_plus4)
   );

   always_ff @(posedge clk) begin
      if (rst) begin
         state       <= FETCH;
         imem_ren    <= 1'b0;
         imem_addr   <= RESET_PC;
         instr_valid <= 1'b0;
         instruction <= NOP_INSTR;
      end else begin
         case (state)
            FETCH: begin
               imem_ren <= 1'b1;
               if (redirect) begin
                  // Without a response the old request is still in flight, so it must drain first.
                  if (imem_ready) imem_addr <= target;
                  else            state     <= DRAIN;
               end else if (imem_ready) begin
                  instruction <= imem_data;
                  instr_valid <= 1'b1;
                  imem_ren    <= 1'b0;
                  state       <= VALID;
               end
            end
            VALID: begin
               if (redirect || instr_ready) begin
                  instr_valid <= 1'b0;
                  imem_ren    <= 1'b1;
                  imem_addr   <= redirect ? target : pc_plus4;
                  state       <= FETCH;
               end
            end
            DRAIN: begin
               imem_ren <= 1'b1;
               if (imem_ready) begin
                  imem_addr <= redirect ? target : req_addr;
                  state     <= FETCH;
               end
            end
            default: begin
               state       <= FETCH;
               imem_ren    <= 1'b1;
               instr_valid <= 1'b0;
               imem_addr   <= req_addr;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_instr_fetch.sv
// Self-checking bench for instr_fetch: directed vector table, then random traffic vs. a reference model.
module tb_instr_fetch;
   import cpu_pkg::*;

   logic        clk = 1'b0;
   logic        rst;
   logic        imem_ren;
   logic [31:0] imem_addr;
   logic        imem_ready;
   logic [31:0] imem_data;
   logic        redirect;
   logic [31:0] redirect_pc;
   logic        instr_ready;
   logic        instr_valid;
   logic [31:0] instruction;
   logic [31:0] pc;
   logic [31:0] pc_plus4;

   always #5 clk = ~clk;

   instr_fetch #(.RESET_PC(32'h0000_0000)) dut (
      .clk         (clk),
      .rst         (rst),
      .imem_ren    (imem_ren),
      .imem_addr   (imem_addr),
      .imem_ready  (imem_ready),
      .imem_data   (imem_data),
      .redirect    (redirect),
      .redirect_pc (redirect_pc),
      .instr_ready (instr_ready),
      .instr_valid (instr_valid),
      .instruction (instruction),
      .pc          (pc),
      .pc_plus4    (pc_plus4)
   );

   typedef struct {
      logic        r;
      logic        rdy;
      logic [31:0] d;
      logic        rd;
      logic [31:0] rp;
      logic        ir;
      logic        e_valid;
      logic        e_ren;
      logic [31:0] e_addr;
      logic [31:0] e_pc;
      logic [31:0] e_instr;
      logic        ci;
   } vec_t;

   vec_t vecs[$];
   int   n_cmp = 0;
   int   n_err = 0;

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
      end
   endtask

   task automatic add(input logic r, input logic rdy, input logic [31:0] d, input logic rd,
                      input logic [31:0] rp, input logic ir, input logic ev, input logic er,
                      input logic [31:0] ea, input logic [31:0] ep, input logic [31:0] ei,
                      input logic ci);
      vec_t v;
      v.r = r; v.rdy = rdy; v.d = d; v.rd = rd; v.rp = rp; v.ir = ir;
      v.e_valid = ev; v.e_ren = er; v.e_addr = ea; v.e_pc = ep; v.e_instr = ei; v.ci = ci;
      vecs.push_back(v);
   endtask

   // Reference model: abstract view of the fetch unit (holding a word? discarding one?).
   logic        m_valid, m_ren, m_flush;
   logic [31:0] m_addr, m_pc, m_instr, m_target;

   task automatic model_step(input logic r, input logic rdy, input logic [31:0] d,
                             input logic rd, input logic [31:0] rp, input logic ir);
      logic [31:0] tgt;
      tgt = {rp[31:2], 2'b00};
      if (r) begin
         m_valid = 1'b0; m_ren = 1'b0; m_flush = 1'b0;
         m_addr = 32'h0; m_pc = 32'h0; m_instr = NOP_INSTR; m_target = 32'h0;
      end else begin
         if (m_valid) begin
            if (rd) begin
               m_pc = tgt; m_addr = tgt; m_valid = 1'b0;
            end else if (ir) begin
               m_addr = m_pc + 32'd4; m_pc = m_pc + 32'd4; m_valid = 1'b0;
            end
         end else if (m_flush) begin
            if (rd) begin
               m_target = tgt; m_pc = tgt;
            end
            if (rdy) begin
               m_flush = 1'b0; m_addr = m_target;
            end
         end else begin
            if (rd) begin
               m_pc = tgt;
               if (rdy) m_addr = tgt;
               else begin
                  m_flush = 1'b1; m_target = tgt;
               end
            end else if (rdy) begin
               m_instr = d; m_valid = 1'b1;
            end
         end
         m_ren = !m_valid;
      end
   endtask

   task automatic drive(input logic r, input logic rdy, input logic [31:0] d,
                        input logic rd, input logic [31:0] rp, input logic ir);
      rst = r; imem_ready = rdy; imem_data = d; redirect = rd; redirect_pc = rp; instr_ready = ir;
   endtask

   initial begin
      drive(1'b1, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0);

      //  r rdy data          rd rpc           ir  ev er addr          pc            instr         ci
      add(1, 0, 32'h0,        0, 32'h0,        0,  0, 0, 32'h0,        32'h0,        NOP_INSTR,    1);
      add(1, 1, 32'h1234_5678,0, 32'h0,        0,  0, 0, 32'h0,        32'h0,        NOP_INSTR,    1);
      add(0, 0, 32'h0,        0, 32'h0,        0,  0, 1, 32'h0,        32'h0,        NOP_INSTR,    1);
      add(0, 0, 32'h0,        0, 32'h0,        0,  0, 1, 32'h0,        32'h0,        NOP_INSTR,    1);
      add(0, 1, 32'hAAAAA537, 0, 32'h0,        0,  1, 0, 32'h0,        32'h0,        32'hAAAAA537, 1);
      for (int i = 0; i < 5; i++)
         add(0, 0, 32'hBAD0_BAD0, 0, 32'h0,    0,  1, 0, 32'h0,        32'h0,        32'hAAAAA537, 1);
      add(0, 0, 32'h0,        0, 32'h0,        1,  0, 1, 32'h4,        32'h4,        32'h0,        0);
      add(0, 1, 32'h1111_1111,0, 32'h0,        0,  1, 0, 32'h4,        32'h4,        32'h1111_1111,1);
      add(0, 0, 32'h0,        0, 32'h0,        1,  0, 1, 32'h8,        32'h8,        32'h0,        0);
      add(0, 0, 32'h0,        1, 32'h200,      0,  0, 1, 32'h8,        32'h200,      32'h0,        0);
      add(0, 0, 32'h0,        0, 32'h0,        0,  0, 1, 32'h8,        32'h200,      32'h0,        0);
      add(0, 1, 32'hDEADBEEF, 0, 32'h0,        0,  0, 1, 32'h200,      32'h200,      32'h0,        0);
      add(0, 1, 32'h44,       0, 32'h0,        0,  1, 0, 32'h200,      32'h200,      32'h44,       1);
      add(0, 0, 32'h0,        1, 32'h103,      1,  0, 1, 32'h100,      32'h100,      32'h0,        0);
      add(0, 1, 32'h55,       0, 32'h0,        0,  1, 0, 32'h100,      32'h100,      32'h55,       1);
      add(0, 0, 32'h0,        1, 32'hFFFFFFFC, 0,  0, 1, 32'hFFFFFFFC, 32'hFFFFFFFC, 32'h0,        0);
      add(0, 1, 32'h66,       0, 32'h0,        0,  1, 0, 32'hFFFFFFFC, 32'hFFFFFFFC, 32'h66,       1);
      add(0, 0, 32'h0,        0, 32'h0,        1,  0, 1, 32'h0,        32'h0,        32'h0,        0);
      add(0, 0, 32'h0,        1, 32'h300,      0,  0, 1, 32'h0,        32'h300,      32'h0,        0);
      add(0, 0, 32'h0,        1, 32'h402,      0,  0, 1, 32'h0,        32'h400,      32'h0,        0);
      add(1, 0, 32'h0,        0, 32'h0,        0,  0, 0, 32'h0,        32'h0,        NOP_INSTR,    1);
      add(0, 0, 32'h0,        0, 32'h0,        0,  0, 1, 32'h0,        32'h0,        NOP_INSTR,    1);
      add(0, 1, 32'h77,       1, 32'h500,      0,  0, 1, 32'h500,      32'h500,      32'h0,        0);
      add(0, 1, 32'h88,       0, 32'h0,        0,  1, 0, 32'h500,      32'h500,      32'h88,       1);
      add(0, 0, 32'h0,        0, 32'h0,        1,  0, 1, 32'h504,      32'h504,      32'h0,        0);
      add(0, 0, 32'h0,        1, 32'h600,      0,  0, 1, 32'h504,      32'h600,      32'h0,        0);
      add(0, 1, 32'h0,        1, 32'h700,      0,  0, 1, 32'h700,      32'h700,      32'h0,        0);
      add(0, 1, 32'h99,       0, 32'h0,        0,  1, 0, 32'h700,      32'h700,      32'h99,       1);

      foreach (vecs[k]) begin
         drive(vecs[k].r, vecs[k].rdy, vecs[k].d, vecs[k].rd, vecs[k].rp, vecs[k].ir);
         @(posedge clk);
         #1;
         chk($sformatf("vec%0d instr_valid", k), {31'b0, instr_valid}, {31'b0, vecs[k].e_valid});
         chk($sformatf("vec%0d imem_ren", k), {31'b0, imem_ren}, {31'b0, vecs[k].e_ren});
         if (vecs[k].e_ren)
            chk($sformatf("vec%0d imem_addr", k), imem_addr, vecs[k].e_addr);
         chk($sformatf("vec%0d pc", k), pc, vecs[k].e_pc);
         chk($sformatf("vec%0d pc_plus4", k), pc_plus4, vecs[k].e_pc + 32'd4);
         if (vecs[k].ci)
            chk($sformatf("vec%0d instruction", k), instruction, vecs[k].e_instr);
      end

      // Random traffic against the reference model.
      for (int c = 0; c < 3000; c++) begin
         logic        r, rdy, rd, ir;
         logic [31:0] d, rp;
         r   = (c < 2) || ($urandom_range(0, 149) == 0);
         rdy = ($urandom_range(0, 2) == 0);
         d   = $urandom;
         rd  = ($urandom_range(0, 7) == 0);
         rp  = ($urandom_range(0, 9) == 0) ? 32'hFFFF_FFFC : $urandom;
         ir  = $urandom_range(0, 1) == 1;
         drive(r, rdy, d, rd, rp, ir);
         @(posedge clk);
         model_step(r, rdy, d, rd, rp, ir);
         #1;
         chk("rnd instr_valid", {31'b0, instr_valid}, {31'b0, m_valid});
         chk("rnd imem_ren", {31'b0, imem_ren}, {31'b0, m_ren});
         if (m_ren) chk("rnd imem_addr", imem_addr, m_addr);
         chk("rnd pc", pc, m_pc);
         chk("rnd pc_plus4", pc_plus4, m_pc + 32'd4);
         if (m_valid || r) chk("rnd instruction", instruction, m_instr);
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
